// File: rtl/multi_rect_object.sv
// Draws up to NUM_OBJ double-buffered rectangles with fixed lowest-index priority and flags overlaps.
// Latency: 1 clk from pixel to outputs. Backpressure: none; a new pixel is accepted every cycle.
module multi_rect_object #(
    parameter int          NUM_OBJ              = 4,
    parameter int          CW                   = 11,
    parameter logic [7:0]  TRANSPARENT_ENCODING = 8'hFF,
    localparam int         IW                   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic signed [CW-1:0] pixelX,
    input  logic signed [CW-1:0] pixelY,
    input  logic                 startOfFrame,
    input  logic                 wrEn,
    input  logic [IW-1:0]        wrIdx,
    input  logic signed [CW-1:0] wrTopLeftX,
    input  logic signed [CW-1:0] wrTopLeftY,
    input  logic [CW-1:0]        wrWidth,
    input  logic [CW-1:0]        wrHeight,
    input  logic [7:0]           wrColor,
    input  logic                 wrVisible,
    output logic [CW-1:0]        offsetX,
    output logic [CW-1:0]        offsetY,
    output logic                 drawingRequest,
    output logic [7:0]           RGBout,
    output logic [IW-1:0]        hitIndex,
    output logic                 collisionLive,
    output logic                 collisionFrame
);

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        logic [7:0]    color;
        logic          vis;
    } rect_t;

    rect_t sh_q  [NUM_OBJ];
    rect_t sh_d  [NUM_OBJ];
    rect_t act_q [NUM_OBJ];
    rect_t act_d [NUM_OBJ];
    rect_t wr_rect;

    logic               wr_ok;
    logic [NUM_OBJ-1:0] wr_sel;
    logic [NUM_OBJ-1:0] in_rect;
    logic               overlap;

    logic          dr_q, dr_d;
    logic [7:0]    rgb_q, rgb_d;
    logic [CW-1:0] offx_q, offx_d, offy_q, offy_d;
    logic [IW-1:0] hit_q, hit_d;
    logic          clive_q, clive_d;
    logic          cframe_q, cframe_d;

    assign wr_rect = '{x: wrTopLeftX, y: wrTopLeftY, w: wrWidth, h: wrHeight,
                       color: wrColor, vis: wrVisible};
    assign wr_ok   = 32'(wrIdx) < NUM_OBJ;

    // A write coinciding with startOfFrame bypasses the shadow so it is drawn in the new frame.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            wr_sel[i] = wrEn && wr_ok && (wrIdx == IW'(i));
            sh_d[i]   = sh_q[i];
            act_d[i]  = act_q[i];
            if (wr_sel[i]) begin
                sh_d[i] = wr_rect;
            end
            if (startOfFrame) begin
                act_d[i] = wr_sel[i] ? wr_rect : sh_q[i];
            end
        end
    end

    // Hit test is done two bits wider so X+W never wraps for rectangles near the coordinate limits.
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_ch
        logic signed [CW+1:0] px, py, x0, y0, x1, y1;
        assign px = {{2{pixelX[CW-1]}}, pixelX};
        assign py = {{2{pixelY[CW-1]}}, pixelY};
        assign x0 = {{2{act_q[g].x[CW-1]}}, act_q[g].x};
        assign y0 = {{2{act_q[g].y[CW-1]}}, act_q[g].y};
        assign x1 = x0 + $signed({2'b00, act_q[g].w});
        assign y1 = y0 + $signed({2'b00, act_q[g].h});
        assign in_rect[g] = act_q[g].vis && (|act_q[g].w) && (|act_q[g].h) &&
                            (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    end

    // Two or more bits set in in_rect means at least one pair of channels overlaps here.
    assign overlap = |(in_rect & (in_rect - NUM_OBJ'(1)));

    always_comb begin
        dr_d   = 1'b0;
        rgb_d  = TRANSPARENT_ENCODING;
        offx_d = '0;
        offy_d = '0;
        hit_d  = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (in_rect[i] && !dr_d) begin
                dr_d   = 1'b1;
                rgb_d  = act_q[i].color;
                offx_d = pixelX - act_q[i].x;
                offy_d = pixelY - act_q[i].y;
                hit_d  = IW'(i);
            end
        end
        clive_d  = startOfFrame ? 1'b0 : (clive_q | overlap);
        cframe_d = startOfFrame ? (clive_q | overlap) : cframe_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
            dr_q     <= 1'b0;
            rgb_q    <= TRANSPARENT_ENCODING;
            offx_q   <= '0;
            offy_q   <= '0;
            hit_q    <= '0;
            clive_q  <= 1'b0;
            cframe_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_q[i]  <= sh_d[i];
                act_q[i] <= act_d[i];
            end
            dr_q     <= dr_d;
            rgb_q    <= rgb_d;
            offx_q   <= offx_d;
            offy_q   <= offy_d;
            hit_q    <= hit_d;
            clive_q  <= clive_d;
            cframe_q <= cframe_d;
        end
    end

    assign drawingRequest = dr_q;
    assign RGBout         = rgb_q;
    assign offsetX        = offx_q;
    assign offsetY        = offy_q;
    assign hitIndex       = hit_q;
    assign collisionLive  = clive_q;
    assign collisionFrame = cframe_q;

endmodule

// File: tb/tb_multi_rect_object.sv
// Directed bench for multi_rect_object: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_multi_rect_object;

    localparam int NOBJ = 5;
    localparam int CW   = 11;
    localparam int IW   = 3;

    logic                 clk = 1'b0;
    logic                 resetN = 1'b0;
    logic signed [CW-1:0] pixelX = '0, pixelY = '0;
    logic                 startOfFrame = 1'b0;
    logic                 wrEn = 1'b0;
    logic [IW-1:0]        wrIdx = '0;
    logic signed [CW-1:0] wrTopLeftX = '0, wrTopLeftY = '0;
    logic [CW-1:0]        wrWidth = '0, wrHeight = '0;
    logic [7:0]           wrColor = '0;
    logic                 wrVisible = 1'b0;
    logic [CW-1:0]        offsetX, offsetY;
    logic                 drawingRequest;
    logic [7:0]           RGBout;
    logic [IW-1:0]        hitIndex;
    logic                 collisionLive, collisionFrame;

    multi_rect_object #(.NUM_OBJ(NOBJ), .CW(CW), .TRANSPARENT_ENCODING(8'hFF)) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .wrEn(wrEn), .wrIdx(wrIdx),
        .wrTopLeftX(wrTopLeftX), .wrTopLeftY(wrTopLeftY), .wrWidth(wrWidth),
        .wrHeight(wrHeight), .wrColor(wrColor), .wrVisible(wrVisible),
        .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest),
        .RGBout(RGBout), .hitIndex(hitIndex), .collisionLive(collisionLive),
        .collisionFrame(collisionFrame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        dr;
        logic [7:0]  rgb;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [2:0]  hit;
        logic        cl;
        logic        cf;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic e_cl = 1'b0, e_cf = 1'b0;

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (e.due != cyc || drawingRequest !== e.dr || RGBout !== e.rgb ||
                    offsetX !== e.ox || offsetY !== e.oy || hitIndex !== e.hit ||
                    collisionLive !== e.cl || collisionFrame !== e.cf) begin
                    failures++;
                    $display("FAIL %s: got dr=%b rgb=%h ox=%0d oy=%0d hit=%0d cl=%b cf=%b, want dr=%b rgb=%h ox=%0d oy=%0d hit=%0d cl=%b cf=%b (due %0d at %0d)",
                             e.nm, drawingRequest, RGBout, offsetX, offsetY, hitIndex,
                             collisionLive, collisionFrame, e.dr, e.rgb, e.ox, e.oy,
                             e.hit, e.cl, e.cf, e.due, cyc);
                end
            end
        end
    end

    task automatic push(input bit dr, input logic [7:0] rgb, input int ox, input int oy,
                        input int hit, input string nm);
        exp_t e;
        e.due = cyc + 1; e.dr = dr; e.rgb = rgb; e.ox = 11'(ox); e.oy = 11'(oy);
        e.hit = 3'(hit); e.cl = e_cl; e.cf = e_cf; e.nm = nm;
        q.push_back(e);
    endtask

    // One cycle: drive pixel/sof at the falling edge, optionally queue the expectation.
    task automatic step(input bit s, input int px, input int py, input bit chk,
                        input bit dr, input logic [7:0] rgb, input int ox, input int oy,
                        input int hit, input string nm);
        pixelX = 11'(px);
        pixelY = 11'(py);
        startOfFrame = s;
        if (chk) push(dr, rgb, ox, oy, hit, nm);
        @(negedge clk);
        startOfFrame = 1'b0;
        wrEn = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input bit dr, input logic [7:0] rgb,
                       input int ox, input int oy, input int hit, input string nm);
        step(1'b0, px, py, 1'b1, dr, rgb, ox, oy, hit, nm);
    endtask

    task automatic miss(input int px, input int py, input string nm);
        step(1'b0, px, py, 1'b1, 1'b0, 8'hFF, 0, 0, 0, nm);
    endtask

    task automatic idle();
        step(1'b0, 1000, 1000, 1'b0, 1'b0, 8'hFF, 0, 0, 0, "idle");
    endtask

    task automatic sof(input bit chk, input string nm);
        step(1'b1, 1000, 1000, chk, 1'b0, 8'hFF, 0, 0, 0, nm);
    endtask

    // Sets the write port; the following step() carries it into one clock edge.
    task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                      input logic [7:0] c, input bit v);
        wrEn = 1'b1; wrIdx = 3'(idx);
        wrTopLeftX = 11'(x); wrTopLeftY = 11'(y);
        wrWidth = 11'(w); wrHeight = 11'(h);
        wrColor = c; wrVisible = v;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        miss(0, 0, "reset_idle");

        // Basic single rectangle
        wr(0, 10, 20, 5, 5, 8'h1C, 1'b1); idle();
        sof(1'b1, "sof_first");
        pix(12, 22, 1'b1, 8'h1C, 2, 2, 0, "ch0_inside");
        miss(15, 22, "ch0_right_edge");
        pix(14, 24, 1'b1, 8'h1C, 4, 4, 0, "ch0_last_pixel");

        // Overlap, priority and collision flags
        wr(1, 0, 0, 10, 10, 8'h33, 1'b1); idle();
        wr(2, 5, 5, 10, 10, 8'h44, 1'b1); idle();
        sof(1'b0, "");
        e_cl = 1'b1;
        pix(6, 6, 1'b1, 8'h33, 6, 6, 1, "overlap_prio");
        pix(12, 12, 1'b1, 8'h44, 7, 7, 2, "ch2_only");
        e_cl = 1'b0; e_cf = 1'b1;
        sof(1'b1, "sof_colframe");
        miss(1000, 1000, "colframe_hold");
        step(1'b1, 6, 6, 1'b1, 1'b1, 8'h33, 6, 6, 1, "sof_overlap");
        miss(1000, 1000, "no_carry");
        e_cf = 1'b0;
        sof(1'b1, "colframe_clear");

        // Negative position and coordinate-limit rectangle
        wr(0, -4, -4, 8, 8, 8'h55, 1'b1); idle();
        wr(1, 0, 0, 10, 10, 8'h33, 1'b0); idle();
        wr(2, 5, 5, 10, 10, 8'h44, 1'b0); idle();
        wr(4, 1020, 0, 10, 10, 8'h66, 1'b1); idle();
        sof(1'b0, "");
        pix(0, 0, 1'b1, 8'h55, 4, 4, 0, "neg_origin");
        miss(4, 0, "neg_right_edge");
        pix(-4, 3, 1'b1, 8'h55, 0, 7, 0, "neg_corner");
        miss(-5, 0, "neg_left_out");
        pix(1022, 5, 1'b1, 8'h66, 2, 5, 4, "limit_inside");
        miss(-1020, 5, "limit_no_wrap");

        // Double buffering
        wr(3, 100, 100, 10, 10, 8'h77, 1'b1); idle();
        miss(105, 105, "shadow_not_drawn");
        sof(1'b1, "sof_commit");
        pix(105, 105, 1'b1, 8'h77, 5, 5, 3, "shadow_committed");
        wr(2, 300, 300, 5, 5, 8'h99, 1'b1); idle();
        wr(3, 200, 200, 4, 4, 8'h88, 1'b1);
        sof(1'b1, "sof_with_write");
        pix(201, 201, 1'b1, 8'h88, 1, 1, 3, "coincident_write");
        miss(105, 105, "old_ch3_gone");
        pix(301, 301, 1'b1, 8'h99, 1, 1, 2, "other_ch_commit");

        // Zero width and out-of-range index
        wr(1, 400, 400, 0, 5, 8'hAA, 1'b1); idle();
        wr(5, 500, 500, 5, 5, 8'hBB, 1'b1); idle();
        sof(1'b0, "");
        miss(400, 402, "zero_width");
        miss(501, 501, "idx_out_of_range");
        pix(301, 301, 1'b1, 8'h99, 1, 1, 2, "ch2_unchanged");

        // Reset in mid-frame with a pending shadow write
        pix(-4, 0, 1'b1, 8'h55, 0, 4, 0, "pre_reset");
        wr(0, 600, 600, 5, 5, 8'hCC, 1'b1); idle();
        pixelX = -11'sd4; pixelY = 11'sd0;
        resetN = 1'b0;
        push(1'b0, 8'hFF, 0, 0, 0, "in_reset");
        @(negedge clk);
        resetN = 1'b1;
        miss(-4, 0, "post_reset_idle");
        sof(1'b1, "post_reset_sof");
        miss(601, 601, "pending_discarded");
        miss(-4, 0, "old_active_cleared");
        miss(201, 201, "ch3_cleared");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            failures++;
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
